seq_detect_ctrl: RTL and testbench

Run-time-programmable serial pattern detection controller for the bit-serial sequence detection path. It loads a pattern of up to MAX_LEN bits, its length, a match target and an idle timeout through a config handshake. It then scans a qualified serial bit stream with overlapping matches, counts matches, and terminates on target reached, timeout or abort. It sits between the stimulus/capture logic and the status registers and replaces the fixed-pattern detectors wherever the pattern must change without resynthesis.

---
 rtl/seq_detect_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//
// Run-time programmable serial pattern detector. A pattern of up to MAX_LEN
// bits, its length, a match target and an idle timeout are loaded through a
// valid/ready config port. A run then scans the qualified serial stream with
// overlapping matches, counts them, and finishes on target reached, on idle
// timeout, or returns to idle on abort.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cfg_valid/ready  config handshake (ready only while not running)
//   cfg_pattern      pattern, cfg_pattern[len-1] is the first bit received
//   cfg_len          pattern length, values above MAX_LEN clamp to MAX_LEN
//   cfg_target       matches needed to finish, 0 = unlimited
//   cfg_timeout      idle cycles allowed between matches, 0 = disabled
//   start, abort     run control
//   a_valid, a       serial bit stream and its qualifier
//   detected         one-cycle pulse per match
//   match_count      matches in the current/last run (saturating)
//   busy             run in progress
//   done, timed_out  run finished / finished by timeout, held until next
//                    start, config transfer or reset
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic [TO_W-1:0]              cfg_timeout,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         a_valid,
    input  logic                         a,
    output logic                         detected,
    output logic [CNT_W-1:0]             match_count,
    output logic                         busy,
    output logic                         done,
    output logic                         timed_out
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TO_W-1:0]    timeout_q, timeout_d;
    logic [TO_W-1:0]    idleCnt_q, idleCnt_d;
    logic               detected_q, detected_d;
    logic               done_q, done_d;
    logic               timedOut_q, timedOut_d;

    logic               cfgFire;
    logic [LEN_W-1:0]   cfgLenClamped;
    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] lenMask;
    logic [LEN_W-1:0]   fillNext;
    logic [CNT_W-1:0]   countInc;
    logic [TO_W-1:0]    idleInc;
    logic               hit;

    // Datapath helpers. The match is evaluated on the post-shift history so a
    // bit accepted at an edge can complete a match at that same edge. The
    // length mask becomes all ones when len equals MAX_LEN because the shift
    // pushes every bit out.
    assign cfgFire       = cfg_valid && (state_q != RUN);
    assign cfgLenClamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign shifted       = {history_q[MAX_LEN-2:0], a};
    assign fillNext      = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    assign lenMask       = ~({MAX_LEN{1'b1}} << len_q);
    assign hit           = a_valid && (fillNext >= len_q) &&
                           (((shifted ^ pattern_q) & lenMask) == '0);
    assign countInc      = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    assign idleInc       = (idleCnt_q == '1) ? idleCnt_q : idleCnt_q + TO_W'(1);

    // Next-state logic. In IDLE/DONE a config transfer is applied first so a
    // start in the same cycle sees the freshly latched length. In RUN, abort
    // beats everything, and a match beats a timeout landing on the same edge.
    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        history_d  = history_q;
        len_d      = len_q;
        fill_d     = fill_q;
        target_d   = target_q;
        count_d    = count_q;
        timeout_d  = timeout_q;
        idleCnt_d  = idleCnt_q;
        detected_d = 1'b0;
        done_d     = done_q;
        timedOut_d = timedOut_q;

        case (state_q)
            IDLE, DONE: begin
                if (cfgFire) begin
                    pattern_d  = cfg_pattern;
                    len_d      = cfgLenClamped;
                    target_d   = cfg_target;
                    timeout_d  = cfg_timeout;
                    state_d    = IDLE;
                    done_d     = 1'b0;
                    timedOut_d = 1'b0;
                end
                if (start && (len_d != '0)) begin
                    state_d    = RUN;
                    history_d  = '0;
                    fill_d     = '0;
                    count_d    = '0;
                    idleCnt_d  = '0;
                    done_d     = 1'b0;
                    timedOut_d = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (a_valid) begin
                        history_d = shifted;
                        fill_d    = fillNext;
                    end
                    if (hit) begin
                        detected_d = 1'b1;
                        count_d    = countInc;
                        idleCnt_d  = '0;
                        if ((target_q != '0) && (countInc == target_q)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idleCnt_d = idleInc;
                        if ((timeout_q != '0) && (idleInc == timeout_q)) begin
                            state_d    = DONE;
                            done_d     = 1'b1;
                            timedOut_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset also wipes the latched config, so a
    // start right after reset is ignored until a new config arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pattern_q  <= '0;
            history_q  <= '0;
            len_q      <= '0;
            fill_q     <= '0;
            target_q   <= '0;
            count_q    <= '0;
            timeout_q  <= '0;
            idleCnt_q  <= '0;
            detected_q <= 1'b0;
            done_q     <= 1'b0;
            timedOut_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            history_q  <= history_d;
            len_q      <= len_d;
            fill_q     <= fill_d;
            target_q   <= target_d;
            count_q    <= count_d;
            timeout_q  <= timeout_d;
            idleCnt_q  <= idleCnt_d;
            detected_q <= detected_d;
            done_q     <= done_d;
            timedOut_q <= timedOut_d;
        end
    end

    assign cfg_ready   = (state_q != RUN);
    assign busy        = (state_q == RUN);
    assign detected    = detected_q;
    assign match_count = count_q;
    assign done        = done_q;
    assign timed_out   = timedOut_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//
// Self-checking bench for seq_detect_ctrl. A behavioural reference model keeps
// every received bit of the current run and compares the tail against the
// pattern; its expected outputs are pushed to a scoreboard queue at each edge
// and popped when the DUT outputs are sampled 1 ns later. Each scenario task
// also checks hand-derived match positions and final status values.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int TO_W    = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic [TO_W-1:0]    cfg_timeout = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               a_valid = 1'b0;
    logic               a = 1'b0;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;
    logic               timed_out;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W),
        .TO_W   (TO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_target (cfg_target),
        .cfg_timeout(cfg_timeout),
        .start      (start),
        .abort      (abort),
        .a_valid    (a_valid),
        .a          (a),
        .detected   (detected),
        .match_count(match_count),
        .busy       (busy),
        .done       (done),
        .timed_out  (timed_out)
    );

    typedef struct packed {
        logic rst;
        logic cv;
        logic st;
        logic ab;
        logic av;
        logic a;
    } stim_t;

    typedef struct packed {
        logic             det;
        logic [CNT_W-1:0] cnt;
        logic             busy;
        logic             done;
        logic             to;
        logic             rdy;
    } obs_t;

    obs_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0 idle, 1 run, 2 done
    int               mState = 0;
    logic [MAX_LEN-1:0] mPat = '0;
    int               mLen = 0;
    int               mTarget = 0;
    int               mTimeout = 0;
    int               mIdle = 0;
    int               mCount = 0;
    bit               mDet = 0;
    bit               mDone = 0;
    bit               mTo = 0;
    bit               recv[$];

    function automatic stim_t mk(logic r, logic cv, logic st, logic ab, logic av, logic b);
        stim_t s;
        s.rst = r;
        s.cv  = cv;
        s.st  = st;
        s.ab  = ab;
        s.av  = av;
        s.a   = b;
        return s;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("det=%0b cnt=%0d busy=%0b done=%0b to=%0b rdy=%0b",
                         o.det, o.cnt, o.busy, o.done, o.to, o.rdy);
    endfunction

    task automatic setCfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                          input logic [CNT_W-1:0] t, input logic [TO_W-1:0] tmo);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_target  = t;
        cfg_timeout = tmo;
    endtask

    task automatic modelStep();
        bit hit;
        mDet = 0;
        if (rst) begin
            mState = 0; mPat = '0; mLen = 0; mTarget = 0; mTimeout = 0;
            mIdle = 0; mCount = 0; mDone = 0; mTo = 0;
            recv.delete();
        end else if (mState != 1) begin
            if (cfg_valid) begin
                mPat     = cfg_pattern;
                mLen     = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
                mTarget  = int'(cfg_target);
                mTimeout = int'(cfg_timeout);
                mState   = 0;
                mDone    = 0;
                mTo      = 0;
            end
            if (start && mLen != 0) begin
                mState = 1;
                recv.delete();
                mCount = 0;
                mIdle  = 0;
                mDone  = 0;
                mTo    = 0;
            end
        end else if (abort) begin
            mState = 0;
        end else begin
            hit = 0;
            if (a_valid) begin
                recv.push_back(a);
                if (recv.size() >= mLen) begin
                    hit = 1;
                    for (int i = 0; i < mLen; i++)
                        if (recv[recv.size() - 1 - i] != mPat[i]) hit = 0;
                end
            end
            if (hit) begin
                mDet = 1;
                if (mCount < (1 << CNT_W) - 1) mCount++;
                mIdle = 0;
                if (mTarget != 0 && mCount == mTarget) begin
                    mState = 2;
                    mDone  = 1;
                end
            end else begin
                mIdle++;
                if (mTimeout != 0 && mIdle == mTimeout) begin
                    mState = 2;
                    mDone  = 1;
                    mTo    = 1;
                end
            end
        end
    endtask

    task automatic runOne(input stim_t s, output obs_t g, output obs_t e);
        obs_t m;
        rst       = s.rst;
        cfg_valid = s.cv;
        start     = s.st;
        abort     = s.ab;
        a_valid   = s.av;
        a         = s.a;
        @(posedge clk);
        modelStep();
        m.det  = mDet;
        m.cnt  = CNT_W'(mCount);
        m.busy = (mState == 1);
        m.done = mDone;
        m.to   = mTo;
        m.rdy  = (mState != 1);
        expQ.push_back(m);
        #1;
        g.det  = detected;
        g.cnt  = match_count;
        g.busy = busy;
        g.done = done;
        g.to   = timed_out;
        g.rdy  = cfg_ready;
        e = expQ.pop_front();
    endtask

    task automatic test_reset();
        obs_t g, e;
        for (int i = 0; i < 3; i++) begin
            runOne(mk(i < 2, '0, '0, '0, '0, '0), g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL reset cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
        end
        checks++;
        if ({g.det, g.cnt, g.busy, g.done, g.to} !== '0 || g.rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state got %s exp all zero with rdy=1", fmt(g));
        end
    endtask

    task automatic test_len_zero();
        obs_t g, e;
        stim_t sq[$];
        sq.push_back(mk('0, '0, '1, '0, '1, '1));
        sq.push_back(mk('0, '0, '1, '0, '1, '0));
        sq.push_back(mk('0, '0, '0, '0, '0, '0));
        for (int i = 0; i < sq.size(); i++) begin
            runOne(sq[i], g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL len_zero cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
        end
        checks++;
        if (g.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL len_zero_busy got %0b exp 0", g.busy);
        end
    endtask

    task automatic test_basic();
        obs_t g, e;
        stim_t sq[$];
        int detIdx[$];
        logic [9:0] bits = 10'b1100110011;
        setCfg(8'b0011_0011, 4'd6, 8'd2, 16'd0);
        sq.push_back(mk('0, '1, '0, '0, '0, '0));
        sq.push_back(mk('0, '0, '1, '0, '0, '0));
        for (int n = 9; n >= 0; n--) sq.push_back(mk('0, '0, '0, '0, '1, bits[n]));
        sq.push_back(mk('0, '0, '0, '0, '0, '0));
        sq.push_back(mk('0, '0, '0, '0, '0, '0));
        for (int i = 0; i < sq.size(); i++) begin
            runOne(sq[i], g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL basic cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
            if (g.det === 1'b1) detIdx.push_back(i);
        end
        checks++;
        if (!(detIdx.size() == 2 && detIdx[0] == 7 && detIdx[1] == 11)) begin
            errors++;
            $display("[TB] FAIL basic_det_pos got %p exp 7,11", detIdx);
        end
        checks++;
        if (g.cnt !== 8'd2 || g.done !== 1'b1 || g.rdy !== 1'b1 || g.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_final got %s exp cnt=2 done=1 rdy=1 busy=0", fmt(g));
        end
    endtask

    task automatic test_gapped();
        obs_t g, e;
        stim_t sq[$];
        int detIdx[$];
        logic [9:0] bits = 10'b1100110011;
        setCfg(8'b0011_0011, 4'd6, 8'd2, 16'd0);
        sq.push_back(mk('0, '1, '1, '0, '0, '0));
        for (int n = 9; n >= 0; n--) begin
            sq.push_back(mk('0, '0, '0, '0, '0, ~bits[n]));
            sq.push_back(mk('0, '0, '0, '0, '1, bits[n]));
        end
        sq.push_back(mk('0, '0, '0, '0, '0, '0));
        for (int i = 0; i < sq.size(); i++) begin
            runOne(sq[i], g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL gapped cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
            if (g.det === 1'b1) detIdx.push_back(i);
        end
        checks++;
        if (!(detIdx.size() == 2 && detIdx[0] == 12 && detIdx[1] == 20)) begin
            errors++;
            $display("[TB] FAIL gapped_det_pos got %p exp 12,20", detIdx);
        end
    endtask

    task automatic test_timeout();
        obs_t g, e;
        stim_t sq[$];
        int detIdx[$];
        int firstDone = -1;
        setCfg(8'h0A, 4'd4, 8'd0, 16'd5);
        sq.push_back(mk('0, '1, '0, '0, '0, '0));
        sq.push_back(mk('0, '0, '1, '0, '0, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '0));
        for (int n = 0; n < 8; n++) sq.push_back(mk('0, '0, '0, '0, '0, '0));
        for (int i = 0; i < sq.size(); i++) begin
            runOne(sq[i], g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL timeout cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
            if (g.det === 1'b1) detIdx.push_back(i);
            if (g.done === 1'b1 && firstDone < 0) firstDone = i;
        end
        checks++;
        if (!(detIdx.size() == 1 && detIdx[0] == 5) || firstDone != 10) begin
            errors++;
            $display("[TB] FAIL timeout_pos got det %p done@%0d exp det 5 done@10", detIdx, firstDone);
        end
        checks++;
        if (g.to !== 1'b1 || g.done !== 1'b1 || g.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_final got %s exp done=1 to=1 busy=0", fmt(g));
        end
    endtask

    task automatic test_match_on_timeout();
        obs_t g, e, gHit;
        stim_t sq[$];
        int firstDone = -1;
        sq.push_back(mk('0, '0, '1, '0, '0, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '0));
        for (int n = 0; n < 3; n++) sq.push_back(mk('0, '0, '0, '0, '0, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '0));
        for (int n = 0; n < 6; n++) sq.push_back(mk('0, '0, '0, '0, '0, '0));
        gHit = '0;
        for (int i = 0; i < sq.size(); i++) begin
            runOne(sq[i], g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL match_on_to cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
            if (i == 9) gHit = g;
            if (g.done === 1'b1 && firstDone < 0) firstDone = i;
        end
        checks++;
        if (gHit.det !== 1'b1 || gHit.to !== 1'b0 || gHit.busy !== 1'b1 || gHit.cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL match_on_to_hit got %s exp det=1 cnt=2 busy=1 to=0", fmt(gHit));
        end
        checks++;
        if (firstDone != 14) begin
            errors++;
            $display("[TB] FAIL match_on_to_restart got done@%0d exp done@14", firstDone);
        end
    endtask

    task automatic test_abort();
        obs_t g, e, gAbort, gRestart;
        stim_t sq[$];
        sq.push_back(mk('0, '0, '1, '0, '0, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '1, '1, '0));
        sq.push_back(mk('0, '0, '0, '0, '0, '0));
        sq.push_back(mk('0, '0, '1, '0, '0, '0));
        sq.push_back(mk('0, '0, '0, '0, '0, '0));
        sq.push_back(mk('0, '0, '0, '1, '0, '0));
        gAbort = '0;
        gRestart = '0;
        for (int i = 0; i < sq.size(); i++) begin
            runOne(sq[i], g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL abort cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
            if (i == 6) gAbort = g;
            if (i == 8) gRestart = g;
        end
        checks++;
        if (gAbort.busy !== 1'b0 || gAbort.done !== 1'b0 || gAbort.cnt !== 8'd1 || gAbort.det !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_state got %s exp busy=0 done=0 cnt=1 det=0", fmt(gAbort));
        end
        checks++;
        if (gRestart.cnt !== 8'd0 || gRestart.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_restart got %s exp cnt=0 busy=1", fmt(gRestart));
        end
    endtask

    task automatic test_clamp();
        obs_t g, e;
        stim_t sq[$];
        int detIdx[$];
        logic [7:0] bits = 8'hA5;
        setCfg(8'hA5, 4'd12, 8'd1, 16'd0);
        sq.push_back(mk('0, '1, '1, '0, '0, '0));
        for (int n = 7; n >= 0; n--) sq.push_back(mk('0, '0, '0, '0, '1, bits[n]));
        sq.push_back(mk('0, '0, '0, '0, '0, '0));
        for (int i = 0; i < sq.size(); i++) begin
            runOne(sq[i], g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL clamp cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
            if (g.det === 1'b1) detIdx.push_back(i);
        end
        checks++;
        if (!(detIdx.size() == 1 && detIdx[0] == 8) || g.done !== 1'b1 || g.cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL clamp_match got det %p %s exp det 8 done=1 cnt=1", detIdx, fmt(g));
        end
    endtask

    task automatic test_rst_mid_run();
        obs_t g, e, gRst;
        stim_t sq[$];
        setCfg(8'h0A, 4'd4, 8'd0, 16'd0);
        sq.push_back(mk('0, '1, '0, '0, '0, '0));
        sq.push_back(mk('0, '0, '1, '0, '0, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('1, '0, '0, '0, '1, '0));
        sq.push_back(mk('0, '0, '1, '0, '0, '0));
        sq.push_back(mk('0, '0, '0, '0, '0, '0));
        gRst = '0;
        for (int i = 0; i < sq.size(); i++) begin
            runOne(sq[i], g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL rst_mid cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
            if (i == 5) gRst = g;
        end
        checks++;
        if ({gRst.det, gRst.cnt, gRst.busy, gRst.done, gRst.to} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs got %s exp all zero", fmt(gRst));
        end
        checks++;
        if (g.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_cfg_cleared got busy=%0b exp 0", g.busy);
        end
    endtask

    task automatic test_back_to_back();
        obs_t g, e;
        stim_t sq[$];
        setCfg(8'h03, 4'd3, 8'd0, 16'd0);
        sq.push_back(mk('0, '1, '1, '0, '0, '0));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        sq.push_back(mk('0, '0, '0, '0, '1, '1));
        for (int n = 0; n < 60; n++)
            sq.push_back(mk('0, '0, ($urandom_range(0, 15) == 0), '0,
                            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1))));
        sq.push_back(mk('0, '0, '0, '1, '0, '0));
        for (int i = 0; i < sq.size(); i++) begin
            runOne(sq[i], g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc%0d got %s exp %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_len_zero();
        test_basic();
        test_gapped();
        test_timeout();
        test_match_on_timeout();
        test_abort();
        test_clamp();
        test_rst_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
